// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared segment codes, mode constants and FSM states for result_display
package calc_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_DIV    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Magnitude of a 4-bit field; 4'h8 signed yields 8, which still fits.
  function automatic logic [3:0] nib_mag(input logic [3:0] v, input logic s);
    return (s && v[3]) ? (~v + 4'd1) : v;
  endfunction

endpackage

// File: rtl/result_display_if.sv
// rtl/result_display_if.sv - capture request and display bus between ALU side and result_display
interface result_display_if;
  logic       start;
  logic       mode;
  logic       sign;
  logic [7:0] res;
  logic       busy;
  logic       done;
  logic [7:0] seg;
  logic [3:0] an;

  modport master (output start, mode, sign, res, input busy, done, seg, an);
  modport slave  (input start, mode, sign, res, output busy, done, seg, an);
endinterface

// File: rtl/result_display_seg7_decode.sv
// rtl/result_display_seg7_decode.sv - BCD digit to active-low {dp,g,f,e,d,c,b,a}; >9 is blank
module seg7_decode
  import calc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - ALU result capture, double-dabble to sign+BCD, 4-digit muxed 7-seg drive
// Optional: RESULT_DISPLAY_ZERO_BLANK_EN blanks leading zero hundreds/tens in single-value mode.
module result_display
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  result_display_if.slave bus
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  state_t      state;
  logic        mode_q;
  logic        sign_q;
  logic [7:0]  res_q;
  logic        neg;
  logic        r_neg;
  logic [7:0]  mag;
  logic [3:0]  r_mag;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [2:0]  shift_cnt;
  logic        done_r;
  logic [7:0]  disp [4];
  logic [CW-1:0] scan_cnt;
  logic [1:0]  idx;

  logic [3:0]  dec2_in;
  logic [3:0]  dec0_in;
  logic [7:0]  dec2_seg;
  logic [7:0]  dec1_seg;
  logic [7:0]  dec0_seg;
  logic        blank_h;
  logic        blank_t;
  logic [7:0]  d2_code;
  logic [7:0]  d1_code;
  logic [7:0]  d0_code;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // In divide mode mag[3:0] carries the quotient magnitude.
  assign dec2_in = (mode_q == MODE_DIV) ? mag[3:0] : bcd[11:8];
  assign dec0_in = (mode_q == MODE_DIV) ? r_mag    : bcd[3:0];

  seg7_decode u_dec2 (.bcd(dec2_in),   .seg(dec2_seg));
  seg7_decode u_dec1 (.bcd(bcd[7:4]),  .seg(dec1_seg));
  seg7_decode u_dec0 (.bcd(dec0_in),   .seg(dec0_seg));

`ifdef RESULT_DISPLAY_ZERO_BLANK_EN
  assign blank_h = (bcd[11:8] == 4'd0);
  assign blank_t = blank_h && (bcd[7:4] == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  always_comb begin
    if (mode_q == MODE_DIV) begin
      d2_code = dec2_seg;
      d1_code = r_neg ? SEG_MINUS : SEG_BLANK;
      d0_code = dec0_seg;
    end else begin
      d2_code = blank_h ? SEG_BLANK : dec2_seg;
      d1_code = blank_t ? SEG_BLANK : dec1_seg;
      d0_code = dec0_seg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      done_r    <= 1'b0;
      mode_q    <= 1'b0;
      sign_q    <= 1'b0;
      res_q     <= 8'h00;
      neg       <= 1'b0;
      r_neg     <= 1'b0;
      mag       <= 8'h00;
      r_mag     <= 4'h0;
      bcd       <= 12'h000;
      shift_cnt <= 3'd0;
      for (int i = 0; i < 4; i++) disp[i] <= SEG_BLANK;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            res_q  <= bus.res;
            mode_q <= bus.mode;
            sign_q <= bus.sign;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          neg <= sign_q & res_q[7];
          if (mode_q == MODE_DIV) begin
            mag   <= {4'h0, nib_mag(res_q[7:4], sign_q)};
            r_neg <= sign_q & res_q[3];
            r_mag <= nib_mag(res_q[3:0], sign_q);
            state <= ST_COMMIT;
          end else begin
            mag       <= (sign_q && res_q[7]) ? (~res_q + 8'd1) : res_q;
            bcd       <= 12'h000;
            shift_cnt <= 3'd0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          shift_cnt  <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd7) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp[3] <= neg ? SEG_MINUS : SEG_BLANK;
          disp[2] <= d2_code;
          disp[1] <= d1_code;
          disp[0] <= d0_code;
          done_r  <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Scan runs independently of the converter so the old digits stay lit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_r;
  assign bus.seg  = disp[idx];
  assign bus.an   = ~(4'b0001 << idx);

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - scoreboard bench for result_display (SCAN_DIV=4)
module tb_result_display;

  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  result_display_if bus ();

  result_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [31:0] exp_q [$];

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic m, input logic s, input logic [7:0] r);
    logic [7:0] d3, d2, d1, d0;
    int v, a, h, t, o, qv, rv;
    if (!m) begin
      if (s) v = int'($signed(r));
      else   v = int'(r);
      a = (v < 0) ? -v : v;
      h = a / 100;
      t = (a / 10) % 10;
      o = a % 10;
      d3 = (v < 0) ? 8'hBF : 8'hFF;
      d2 = seg_of(h);
      d1 = seg_of(t);
      d0 = seg_of(o);
`ifdef RESULT_DISPLAY_ZERO_BLANK_EN
      if (h == 0) d2 = 8'hFF;
      if (h == 0 && t == 0) d1 = 8'hFF;
`endif
    end else begin
      qv = int'(r[7:4]);
      rv = int'(r[3:0]);
      if (s && r[7]) qv = qv - 16;
      if (s && r[3]) rv = rv - 16;
      d3 = (qv < 0) ? 8'hBF : 8'hFF;
      d2 = seg_of((qv < 0) ? -qv : qv);
      d1 = (rv < 0) ? 8'hBF : 8'hFF;
      d0 = seg_of((rv < 0) ? -rv : rv);
    end
    return {d3, d2, d1, d0};
  endfunction

  task automatic read_display(output logic [31:0] got);
    got = 32'h0;
    for (int i = 0; i < 4 * SCAN_DIV + 2; i++) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: got[7:0]   = bus.seg;
        4'b1101: got[15:8]  = bus.seg;
        4'b1011: got[23:16] = bus.seg;
        4'b0111: got[31:24] = bus.seg;
        default: ;
      endcase
    end
  endtask

  // second_at >= 0 injects an extra start that many cycles after acceptance.
  task automatic run(input string tag, input logic m, input logic s, input logic [7:0] r,
                     input int lat, input int second_at);
    int k, d0;
    logic [31:0] got, exp;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.sign = s; bus.res = r;
    exp_q.push_back(model(m, s, r));
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
    k = 0;
    while (bus.done !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
      if (k == second_at) begin
        bus.start = 1'b1; bus.mode = 1'b1; bus.sign = 1'b0; bus.res = 8'h99;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, k, lat);
    check({tag, "_busy_done"}, {31'b0, bus.busy}, 32'd0);
    exp = exp_q.pop_front();
    read_display(got);
    check({tag, "_digits"}, got, exp);
    check({tag, "_done_count"}, done_cnt - d0, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.sign = 1'b0; bus.res = 8'h00;
    #12;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_an",   {28'b0, bus.an},   32'h0000000E);
    check("rst_seg",  {24'b0, bus.seg},  32'h000000FF);
    @(negedge clk);
    rst = 1'b1;

    run("neg12", 1'b0, 1'b1, 8'hF4, 10, -1);
    run("u255",  1'b0, 1'b0, 8'hFF, 10, -1);
    run("m128",  1'b0, 1'b1, 8'h80, 10, -1);
    run("u5",    1'b0, 1'b0, 8'h05, 10, -1);
    run("div2f", 1'b1, 1'b1, 8'h2F, 2,  -1);
    run("div83", 1'b1, 1'b1, 8'h83, 2,  -1);

    begin : scan_test
      int w;
      logic [3:0] pat [4];
      pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
      w = 0;
      @(negedge clk);
      while (bus.an === 4'b1110 && w < 20) begin @(negedge clk); w++; end
      while (bus.an !== 4'b1110 && w < 40) begin @(negedge clk); w++; end
      check("scan_align", {31'b0, (w < 40)}, 32'd1);
      for (int c = 0; c < 5 * SCAN_DIV; c++) begin
        check($sformatf("scan_an_%0d", c), {28'b0, bus.an}, {28'b0, pat[(c / SCAN_DIV) % 4]});
        @(negedge clk);
      end
    end

    run("busy_ign", 1'b0, 1'b1, 8'hF4, 10, 3);

    begin : reset_test
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = 1'b0; bus.sign = 1'b0; bus.res = 8'hC8;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
      check("rst_mid_seg",  {24'b0, bus.seg},  32'h000000FF);
      check("rst_mid_an",   {28'b0, bus.an},   32'h0000000E);
      repeat (12) @(negedge clk);
      check("rst_mid_nodone", done_cnt - d0, 0);
      rst = 1'b1;
    end

    run("post_rst", 1'b0, 1'b0, 8'h64, 10, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
